// File: rtl/mpi_arb_pkg.sv
// mpi_arb_pkg: shared types and helpers for the MPI bus DMA arbiter.
//   state_t      - arbiter FSM states
//   OWNER_W      - width of the owner index
//   MAXREQ       - widest requester vector the helpers accept
//   pick_winner  - fixed-priority or round-robin winner selection
package mpi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        OWN,
        REL
    } state_t;

    localparam int OWNER_W = 3;
    localparam int MAXREQ  = 8;

    // Requests are zero-extended to MAXREQ bits by the caller. Because the
    // unused upper bits are zero, wrapping modulo MAXREQ in round-robin mode
    // gives the same answer as wrapping modulo the real requester count.
    function automatic logic [OWNER_W-1:0] pick_winner(
        input logic [MAXREQ-1:0]  req,
        input logic [OWNER_W-1:0] ptr,
        input logic               rr
    );
        logic [OWNER_W-1:0] idx;
        logic [OWNER_W-1:0] pick;
        logic               found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAXREQ; i++) begin
            idx = rr ? (ptr + OWNER_W'(i + 1)) : OWNER_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mpi_sync.sv
// mpi_sync: W-bit two-flop synchronizer, asynchronous reset to 0.
//   clk - destination clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output (two clock edges of latency)
module mpi_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/mpi_dma_arbiter.sv
// mpi_dma_arbiter: DMA bus-mastership arbiter for the MPI system bus.
// Gathers master requests, asks the CPU for the bus (cpu_dmr / cpu_dmgo),
// grants one master, tracks its SACK ownership and times out silent masters.
//   pin_clk  - system clock
//   pin_init - asynchronous active-high reset
//   req      - per-master DMA request (asynchronous)
//   sack     - per-master selection acknowledge (asynchronous)
//   cpu_dmgo - CPU bus release (asynchronous)
//   cpu_dmr  - bus request to the CPU
//   gnt      - one-hot grant to masters
//   owner    - index of current grantee/owner, valid while busy
//   busy     - high in GRANT and OWN
//   tmo      - one-cycle pulse when a grant times out without SACK
module mpi_dma_arbiter
    import mpi_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ACK_TO = 64,
    parameter int RR     = 0
) (
    input  logic               pin_clk,
    input  logic               pin_init,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    sack,
    input  logic               cpu_dmgo,
    output logic               cpu_dmr,
    output logic [NREQ-1:0]    gnt,
    output logic [OWNER_W-1:0] owner,
    output logic               busy,
    output logic               tmo
);

    localparam int TW = $clog2(ACK_TO);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TO - 1);

    logic [NREQ-1:0] rq_s;
    logic [NREQ-1:0] sk_s;
    logic            dg_s;

    mpi_sync #(.W(NREQ)) u_sync_req  (.clk(pin_clk), .rst(pin_init), .d(req),      .q(rq_s));
    mpi_sync #(.W(NREQ)) u_sync_sack (.clk(pin_clk), .rst(pin_init), .d(sack),     .q(sk_s));
    mpi_sync #(.W(1))    u_sync_dmgo (.clk(pin_clk), .rst(pin_init), .d(cpu_dmgo), .q(dg_s));

    state_t             state_reg, state_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic [OWNER_W-1:0] ptr_reg, ptr_next;
    logic [OWNER_W-1:0] owner_reg, owner_next;
    logic [NREQ-1:0]    gnt_reg, gnt_next;
    logic               dmr_reg, dmr_next;
    logic               busy_reg, busy_next;
    logic               tmo_reg, tmo_next;

    // Zero-extended copies so the package helper and the owner index can be
    // used without out-of-range selects when NREQ < MAXREQ.
    logic [MAXREQ-1:0]  rq8;
    logic [MAXREQ-1:0]  sk8;
    logic [OWNER_W-1:0] winner;
    logic [NREQ-1:0]    win_oh;
    logic               sk_own;

    always_comb begin
        rq8 = '0;
        sk8 = '0;
        rq8[NREQ-1:0] = rq_s;
        sk8[NREQ-1:0] = sk_s;
    end

    assign winner = pick_winner(rq8, ptr_reg, RR != 0);
    assign sk_own = sk8[owner_reg];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_win_oh
        assign win_oh[gi] = (winner == OWNER_W'(gi));
    end

    always_ff @(posedge pin_clk or posedge pin_init) begin
        if (pin_init) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            ptr_reg   <= OWNER_W'(NREQ - 1);
            owner_reg <= '0;
            gnt_reg   <= '0;
            dmr_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            tmo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            gnt_reg   <= gnt_next;
            dmr_reg   <= dmr_next;
            busy_reg  <= busy_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        gnt_next   = gnt_reg;
        dmr_next   = dmr_reg;
        tmo_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|rq_s) begin
                    dmr_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dg_s) begin
                    if (|rq_s) begin
                        gnt_next   = win_oh;
                        owner_next = winner;
                        timer_next = '0;
                        state_next = GRANT;
                    end else begin
                        // Requester vanished before the CPU let go: hand the bus back.
                        dmr_next   = 1'b0;
                        state_next = REL;
                    end
                end
            end
            GRANT: begin
                if (!dg_s) begin
                    gnt_next   = '0;
                    dmr_next   = 1'b0;
                    state_next = REL;
                end else if (sk_own) begin
                    gnt_next   = '0;
                    ptr_next   = owner_reg;
                    state_next = OWN;
                end else if (timer_reg == TMO_LAST) begin
                    gnt_next   = '0;
                    tmo_next   = 1'b1;
                    ptr_next   = owner_reg;
                    dmr_next   = 1'b0;
                    state_next = REL;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            OWN: begin
                gnt_next = '0;
                if (!sk_own) begin
                    if (|rq_s) begin
                        // Chain straight to the next master while still holding the bus.
                        gnt_next   = win_oh;
                        owner_next = winner;
                        timer_next = '0;
                        state_next = GRANT;
                    end else begin
                        dmr_next   = 1'b0;
                        state_next = REL;
                    end
                end
            end
            REL: begin
                gnt_next = '0;
                dmr_next = 1'b0;
                if (!dg_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                gnt_next   = '0;
                dmr_next   = 1'b0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == GRANT) || (state_next == OWN);
    end

    assign cpu_dmr = dmr_reg;
    assign gnt     = gnt_reg;
    assign owner   = owner_reg;
    assign busy    = busy_reg;
    assign tmo     = tmo_reg;

endmodule

// File: doc/mpi_dma_arbiter.md
Name: mpi_dma_arbiter

Overview:
- Bus-mastership arbiter for the 1801-family MPI (Q-bus-style) system bus.
- Collects DMA requests from up to NREQ peripheral masters and obtains the bus from the CPU via a DMR/DMGO handshake.
- Issues a one-hot grant to the winner and tracks the SACK ownership interval; times out masters that never acknowledge.
- Sits between the CPU core's bus-release logic and the peripheral DMA controllers, with the gate-array cell library on the pin side.

Parameters:
NREQ, 4, number of DMA requesters (2..8)
ACK_TO, 64, cycles a grant is held waiting for SACK before timeout (>=2)
RR, 0, 0 = fixed priority (index 0 highest), 1 = round-robin

Ports:
pin_clk  in  1  system clock, all state on rising edge
pin_init  in  1  reset, asynchronous, active-high
req  in  NREQ  per-master DMA request (DMR), asynchronous, active-high
sack  in  NREQ  per-master selection acknowledge, asynchronous, active-high
cpu_dmgo  in  1  CPU bus release/grant, asynchronous, active-high
cpu_dmr  out  1  bus request to CPU
gnt  out  NREQ  one-hot grant (DMGO) to masters
owner  out  3  index of current grantee/owner, valid while busy=1
busy  out  1  high in GRANT and OWN states
tmo  out  1  one-cycle pulse on SACK timeout

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0; RR pointer = NREQ-1, so requester 0 wins first. Reset mid-operation drops gnt and cpu_dmr immediately (asynchronously).
- Input sync: req, sack and cpu_dmgo each pass through a 2-flop synchronizer. All decisions use the synchronized values (rq_s, sk_s, dg_s), so an input change is visible 2 cycles later.
- IDLE: if |rq_s, set cpu_dmr=1 and go to REQ.
- REQ: wait for dg_s.
  - On dg_s, latch winner W from rq_s.
    - Fixed priority: lowest set index.
    - RR: first set index after the pointer, wrapping.
  - Set gnt[W]=1, owner=W, timer=0, go to GRANT.
  - If rq_s==0 when dg_s arrives: go to REL and grant nothing.
- GRANT: gnt[W] held; timer increments each cycle.
  - sk_s[W]=1: gnt=0, go to OWN, RR pointer=W.
  - timer reaches ACK_TO-1 without sk_s[W]: gnt=0, tmo=1 for one cycle, RR pointer=W, go to REL.
  - gnt is therefore high exactly ACK_TO cycles.
  - Withdrawal of req[W] during GRANT does not drop gnt; gnt is released only by SACK or timeout.
  - dg_s falling in GRANT: gnt=0, go to REL, no tmo.
- OWN: gnt=0, cpu_dmr stays 1. Wait for sk_s[W] to fall.
  - On the fall with |rq_s: pick a new winner (same rules) and go directly to GRANT. The bus is not returned to the CPU.
  - On the fall with rq_s==0: go to REL.
  - dg_s is ignored in OWN.
- REL: cpu_dmr=0; wait for dg_s=0, then go to IDLE.
- gnt is at most one-hot at all times, and gnt and the OWN state are mutually exclusive.
- sack from a non-owner is ignored in every state.
- Outputs are registered with no combinational input-to-output path. Minimum latency from req rising to gnt rising is 2 (sync) + 1 (cpu_dmr) + CPU latency + 2 (dg sync) + 1 cycles.

Decomposition:
- Package mpi_arb_pkg:
  - state enum: IDLE, REQ, GRANT, OWN, REL
  - OWNER_W = 3
  - function pick_winner(req, ptr, rr), returning the index
- Sub-module mpi_sync: parameterised-width 2-flop synchronizer with async reset to 0. Instantiate it once for req, once for sack, once for cpu_dmgo.
- The FSM, timer and RR pointer live in the top module.

Test Plan:
1. After reset, req=4'b0001; CPU answers dmgo 3 cycles after cpu_dmr; master raises sack 2 cycles after gnt and holds it 10 cycles -> gnt[0] pulse ends 2 cycles after sack rises; owner=0; cpu_dmr falls after sack drops; FSM back in IDLE once dmgo is low.
2. Fixed priority, req=4'b1010 at the same time -> gnt=4'b0010 first. Then with req[3] still pending when sack[1] falls -> gnt=4'b1000 with cpu_dmr held high throughout.
3. RR=1, all four req held high, each master SACKs for 4 cycles -> grant order 0,1,2,3,0.
4. ACK_TO=8, req[2]=1, sack never asserted -> gnt[2] high exactly 8 cycles; tmo pulses once; cpu_dmr drops; busy=0.
5. pin_init asserted while in OWN with cpu_dmr=1 -> cpu_dmr, gnt, busy go to 0 without a clock; after release, req[0] is served normally.
6. req[1] pulse that drops before dmgo, with no other req -> no gnt issued; FSM passes REQ->REL->IDLE; cpu_dmr deasserts.
